gate_sweep_checker: RTL and testbench

- Hardware self-checking engine for parametrised two-operand logic gates.
- On `start`, it drives every operand combination onto a DUT, computes the expected result with an internal reference model, and compares it with the DUT output after a configurable latency.
- Reports pass/fail, a saturating mismatch count, and the first failing vector.
- Sits beside any bitwise gate block (AND/OR/XOR family, WIDTH bits); usable on-board or in simulation.

---
 rtl/gate_sweep_pkg.sv | 36 +++
 rtl/gate_ref_model.sv | 41 ++++
 rtl/gate_sweep_checker.sv | 217 +++++++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
//==============================================================================
// Module      : gate_sweep_pkg
// Description : Shared definitions for the gate sweep checker: gate operation
//               encodings, sweep FSM state type and the vector-count helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gate_sweep_pkg;

    // Gate select encodings (3-bit op field)
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_BUFA = 3'd7;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    // Number of operand combinations for two WIDTH-bit operands
    function automatic int unsigned num_vectors(input int unsigned width);
        return 32'd1 << (2 * width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
//==============================================================================
// Module      : gate_ref_model
// Description : Purely combinational reference model of the two-operand gate
//               family. NOT/BUF act on operand a only.
// Ports       : op [2:0]      - gate select (OP_* encodings)
//               a  [WIDTH-1:0] - operand A
//               b  [WIDTH-1:0] - operand B
//               y  [WIDTH-1:0] - expected bitwise result
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_BUFA: y = a;
            default: y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
//==============================================================================
// Module      : gate_sweep_checker
// Description : Self-checking sweep engine for a bitwise two-operand gate.
//               On start it presents every {a,b} combination (a in the MSBs),
//               compares the gate output DUT_LAT cycles later against an
//               internal reference, and reports pass, a saturating mismatch
//               count and the first failing operands.
// Options     : GATE_SWEEP_STOP_ON_FAIL_EN - when defined, the first mismatch
//               stops issuing vectors; in-flight vectors are still compared.
// Ports       : clk, rst_n          - clock (rising edge), async active-low reset
//               start, op[2:0]      - begin sweep / gate select (latched on start)
//               a_out, b_out        - registered operands to the gate under test
//               y_dut               - gate under test result
//               busy, done, pass    - status (pass valid while done)
//               err_cnt[ERR_W-1:0]  - saturating mismatch count
//               fail_a, fail_b      - operands of the first mismatch
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int               c_VW         = 2 * WIDTH;
    localparam int unsigned      c_NUM_VEC    = num_vectors(WIDTH);
    localparam logic [c_VW-1:0]  c_last_vec   = c_VW'(c_NUM_VEC - 1);
    localparam logic [2:0]       c_drain_last = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

    sweep_state_t       r_state;
    sweep_state_t       w_next_state;

    logic [c_VW-1:0]    r_vec;          // current vector {a, b}
    logic [2:0]         r_op;
    logic [ERR_W-1:0]   r_err;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
    logic               r_first_seen;
    logic [2:0]         r_drain_cnt;

    logic [WIDTH-1:0]   w_ref_y;
    logic               w_cmp_valid;
    logic [WIDTH-1:0]   w_cmp_exp;
    logic [WIDTH-1:0]   w_cmp_a;
    logic [WIDTH-1:0]   w_cmp_b;
    logic               w_mismatch;
    logic               w_stop;
    logic               w_start_ok;
    logic               w_last;

    assign a_out   = r_vec[c_VW-1:WIDTH];
    assign b_out   = r_vec[WIDTH-1:0];
    assign err_cnt = r_err;
    assign fail_a  = r_fail_a;
    assign fail_b  = r_fail_b;

    gate_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .op (r_op),
        .a  (a_out),
        .b  (b_out),
        .y  (w_ref_y)
    );

    // Expected-value delay line: aligns each reference result (and its
    // operands) with the cycle in which the gate output for it is valid.
    generate
        if (DUT_LAT == 0) begin : g_lat_zero
            assign w_cmp_valid = (r_state == ST_SWEEP);
            assign w_cmp_exp   = w_ref_y;
            assign w_cmp_a     = a_out;
            assign w_cmp_b     = b_out;
        end else begin : g_lat_pipe
            logic [DUT_LAT-1:0] r_pv;
            logic [WIDTH-1:0]   r_pe [DUT_LAT];
            logic [WIDTH-1:0]   r_pa [DUT_LAT];
            logic [WIDTH-1:0]   r_pb [DUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    for (int i = 0; i < DUT_LAT; i++) begin
                        r_pe[i] <= '0;
                        r_pa[i] <= '0;
                        r_pb[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= (r_state == ST_SWEEP);
                    r_pe[0] <= w_ref_y;
                    r_pa[0] <= a_out;
                    r_pb[0] <= b_out;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pe[i] <= r_pe[i-1];
                        r_pa[i] <= r_pa[i-1];
                        r_pb[i] <= r_pb[i-1];
                    end
                end
            end

            assign w_cmp_valid = r_pv[DUT_LAT-1];
            assign w_cmp_exp   = r_pe[DUT_LAT-1];
            assign w_cmp_a     = r_pa[DUT_LAT-1];
            assign w_cmp_b     = r_pb[DUT_LAT-1];
        end
    endgenerate

    // Any differing bit marks the whole vector as one mismatch
    assign w_mismatch = w_cmp_valid && (y_dut != w_cmp_exp);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_vec == c_last_vec);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and status outputs
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        pass         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_SWEEP;
            end
            ST_SWEEP: begin
                busy = 1'b1;
                // With no latency the last compare happens on this edge,
                // so there is nothing left to drain.
                if (w_last || w_stop) begin
                    w_next_state = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == c_drain_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (r_err == '0);
                if (start) w_next_state = ST_SWEEP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Vector counter, op latch and scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= '0;
            r_op         <= '0;
            r_err        <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_first_seen <= 1'b0;
            r_drain_cnt  <= '0;
        end else begin
            if (w_start_ok) begin
                r_op         <= op;
                r_vec        <= '0;
                r_err        <= '0;
                r_fail_a     <= '0;
                r_fail_b     <= '0;
                r_first_seen <= 1'b0;
            end else begin
                // Operands advance only while the sweep continues; they
                // hold the last issued vector afterwards.
                if ((r_state == ST_SWEEP) && (w_next_state == ST_SWEEP)) begin
                    r_vec <= r_vec + 1'b1;
                end
                if (w_mismatch) begin
                    if (r_err != '1) r_err <= r_err + 1'b1;
                    if (!r_first_seen) begin
                        r_first_seen <= 1'b1;
                        r_fail_a     <= w_cmp_a;
                        r_fail_b     <= w_cmp_b;
                    end
                end
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? (r_drain_cnt + 3'd1) : 3'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
`timescale 1ns/1ps

module tb_gate_sweep_checker;

    typedef struct {
        string tag;
        int    lat;
        int    err;
        int    pass;
        int    fa;
        int    fb;
    } exp_t;

    exp_t sb[$];     // expected sweep outcomes
    int   vq[$];     // expected operand vectors

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance 1: WIDTH=1, DUT_LAT=0
    logic        start1, busy1, done1, pass1;
    logic [2:0]  op1;
    logic [0:0]  a1, b1, y1, fa1, fb1;
    logic [15:0] err1;
    // Instance 2: WIDTH=2, DUT_LAT=2
    logic        start2, busy2, done2, pass2;
    logic [2:0]  op2;
    logic [1:0]  a2, b2, y2, fa2, fb2, s2;
    logic [15:0] err2;
    // Instance 3: WIDTH=2, DUT_LAT=0, ERR_W=2
    logic        start3, busy3, done3, pass3;
    logic [2:0]  op3;
    logic [1:0]  a3, b3, y3, fa3, fb3;
    logic [1:0]  err3;

    int g1_op, g2_op;
    bit g1_stuck;

    function automatic int gate(input int o, input int a, input int b, input int w);
        int m;
        m = (1 << w) - 1;
        case (o)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b) & m;
            4: return ~(a | b) & m;
            5: return ~(a ^ b) & m;
            6: return ~a & m;
            default: return a;
        endcase
    endfunction

    // Gates under test
    assign y1 = g1_stuck ? 1'b1 : 1'(gate(g1_op, int'(a1), int'(b1), 1));
    always @(posedge clk) begin
        s2 <= 2'(gate(g2_op, int'(a2), int'(b2), 2));
        y2 <= s2;
    end
    assign y3 = a3 & b3;

    gate_sweep_checker #(.WIDTH(1), .DUT_LAT(0), .ERR_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a_out(a1), .b_out(b1),
        .y_dut(y1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_a(fa1), .fail_b(fb1));

    gate_sweep_checker #(.WIDTH(2), .DUT_LAT(2), .ERR_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a_out(a2), .b_out(b2),
        .y_dut(y2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_a(fa2), .fail_b(fb2));

    gate_sweep_checker #(.WIDTH(2), .DUT_LAT(0), .ERR_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .op(op3), .a_out(a3), .b_out(b3),
        .y_dut(y3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .fail_a(fa3), .fail_b(fb3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic snap(input int idx, output logic [31:0] d, output logic [31:0] bz,
                        output logic [31:0] er, output logic [31:0] p,
                        output logic [31:0] fa, output logic [31:0] fb,
                        output logic [31:0] ab);
        case (idx)
            1: begin d = 32'(done1); bz = 32'(busy1); er = 32'(err1); p = 32'(pass1);
                     fa = 32'(fa1); fb = 32'(fb1); ab = 32'({a1, b1}); end
            2: begin d = 32'(done2); bz = 32'(busy2); er = 32'(err2); p = 32'(pass2);
                     fa = 32'(fa2); fb = 32'(fb2); ab = 32'({a2, b2}); end
            default: begin d = 32'(done3); bz = 32'(busy3); er = 32'(err3); p = 32'(pass3);
                     fa = 32'(fa3); fb = 32'(fb3); ab = 32'({a3, b3}); end
        endcase
    endtask

    task automatic set_start(input int idx, input logic s, input logic [2:0] o);
        case (idx)
            1: begin start1 = s; op1 = o; end
            2: begin start2 = s; op2 = o; end
            default: begin start3 = s; op3 = o; end
        endcase
    endtask

    // Expected outcome of a full sweep. dut_kind < 0 models an all-ones output.
    function automatic exp_t model(input string tag, input int w, input int lat,
                                   input int errmax, input int ref_op, input int dut_kind);
        exp_t e;
        int   v, m, fidx, a, b, r, d;
        int   ml[$];
        v = 1 << (2 * w);
        m = (1 << w) - 1;
        fidx = -1;
        e.tag = tag; e.fa = 0; e.fb = 0;
        for (int k = 0; k < v; k++) begin
            a = k >> w;
            b = k & m;
            r = gate(ref_op, a, b, w);
            d = (dut_kind < 0) ? m : gate(dut_kind, a, b, w);
            if (r != d) begin
                if (fidx < 0) begin fidx = k; e.fa = a; e.fb = b; end
                ml.push_back(k);
            end
        end
        e.lat  = v + lat;
        e.err  = ml.size();
        e.pass = (ml.size() == 0) ? 1 : 0;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        if (fidx >= 0 && fidx + lat < v - 1) begin
            e.lat = fidx + 1 + 2 * lat;
            e.err = 0;
            foreach (ml[i]) if (ml[i] <= fidx + lat) e.err++;
        end
`endif
        if (e.err > errmax) e.err = errmax;
        return e;
    endfunction

    task automatic run_sweep(input int idx, input int w, input int lat, input int errmax,
                             input int ref_op, input int dut_kind, input string tag,
                             input bit chk_vec, input int disturb_at);
        exp_t        e, got;
        int          n;
        logic [31:0] d, bz, er, p, fa, fb, ab;
        e = model(tag, w, lat, errmax, ref_op, dut_kind);
        sb.push_back(e);
        vq.delete();
        if (chk_vec) for (int k = 0; k < (1 << (2 * w)); k++) vq.push_back(k);

        @(negedge clk);
        set_start(idx, 1'b1, 3'(ref_op));
        @(posedge clk);
        #1;
        set_start(idx, 1'b0, 3'(ref_op));
        n = 0;
        while (1) begin
            snap(idx, d, bz, er, p, fa, fb, ab);
            if (d == 32'd1) break;
            if (n > e.lat + 10) break;
            if (bz == 32'd1 && vq.size() > 0) check({tag, "_vec"}, ab, 32'(vq.pop_front()));
            if (n == disturb_at)     set_start(idx, 1'b1, 3'(ref_op ^ 1));
            if (n == disturb_at + 1) set_start(idx, 1'b0, 3'(ref_op ^ 1));
            @(posedge clk);
            n++;
            #1;
        end
        check({tag, "_done"}, d, 1);
        got = sb.pop_front();
        check({got.tag, "_latency"}, 32'(n), 32'(got.lat));
        check({got.tag, "_err_cnt"}, er, 32'(got.err));
        check({got.tag, "_pass"}, p, 32'(got.pass));
        check({got.tag, "_fail_a"}, fa, 32'(got.fa));
        check({got.tag, "_fail_b"}, fb, 32'(got.fb));
        repeat (2) @(posedge clk);
        #1;
        snap(idx, d, bz, er, p, fa, fb, ab);
        check({tag, "_done_held"}, d, 1);
        check({tag, "_idle_busy"}, bz, 0);
        set_start(idx, 1'b0, 3'd0);
    endtask

    initial begin : stim
        logic [31:0] d, bz, er, p, fa, fb, ab;
        rst_n = 1'b0;
        start1 = 0; start2 = 0; start3 = 0;
        op1 = 0; op2 = 0; op3 = 0;
        g1_op = 1; g1_stuck = 0; g2_op = 2;

        // Reset state of all instances
        repeat (3) @(posedge clk);
        #1;
        for (int idx = 1; idx <= 3; idx++) begin
            snap(idx, d, bz, er, p, fa, fb, ab);
            check($sformatf("rst%0d_done", idx), d, 0);
            check($sformatf("rst%0d_busy", idx), bz, 0);
            check($sformatf("rst%0d_pass", idx), p, 0);
            check($sformatf("rst%0d_err", idx), er, 0);
            check($sformatf("rst%0d_ops", idx), ab | fa | fb, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // OR, WIDTH=1, no latency, correct gate
        g1_op = 1; g1_stuck = 0;
        run_sweep(1, 1, 0, 65535, 1, 1, "A_or_w1", 1'b1, -1);

        // AND against a stuck-at-1 gate (restart from DONE)
        g1_op = 0; g1_stuck = 1;
        run_sweep(1, 1, 0, 65535, 0, -1, "C_and_stuck1", 1'b0, -1);

        // XOR, WIDTH=2, two-stage registered gate
        g2_op = 2;
        run_sweep(2, 2, 2, 65535, 2, 2, "B_xor_lat2", 1'b1, -1);

        // start pulse and op change mid-sweep must be ignored
        g2_op = 1;
        run_sweep(2, 2, 2, 65535, 1, 1, "E_busy_ignore", 1'b1, 5);

        // Reset in the middle of a sweep
        g2_op = 2;
        @(negedge clk);
        set_start(2, 1'b1, 3'd2);
        @(posedge clk);
        #1;
        set_start(2, 1'b0, 3'd2);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        snap(2, d, bz, er, p, fa, fb, ab);
        check("D_rst_busy", bz, 0);
        check("D_rst_done", d, 0);
        check("D_rst_ops", ab, 0);
        check("D_rst_err", er | fa | fb | p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(2, 2, 2, 65535, 2, 2, "D_after_rst", 1'b1, -1);

        // NAND against an AND gate with a 2-bit counter
        run_sweep(3, 2, 0, 3, 3, 0, "F_nand_sat", 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
